// File: rtl/tt_rebot449_lingret_alu_seq.sv
// tt_rebot449_lingret_alu_seq
// Sequential ALU with valid/ready handshakes on both sides. Logic, add and
// subtract ops finish in one cycle. Multiply is an iterative shift-add that
// consumes one multiplier bit per cycle.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   i_instruction  : op select in bits [2:0]; bits [7:3] are ignored
//   i_data_0       : operand A
//   i_data_1       : operand B
//   i_valid        : request present
//   o_ready        : request accepted this cycle (IDLE only)
//   o_result       : registered result
//   o_flags        : {illegal, overflow, carry, zero}, registered with o_result
//   o_valid        : o_result/o_flags valid (DONE only)
//   i_ready        : downstream consumes the result
module tt_rebot449_lingret_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_instruction,
  input  logic [WIDTH-1:0] i_data_0,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q;
  logic               ready_q, valid_q;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  logic [2:0]         op;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   res_d;
  logic               ill_d, ovf_d, cy_d;
  logic               unused_instr;

  assign op           = i_instruction[2:0];
  assign unused_instr = ^i_instruction[7:3];

  // diff is B-A; its top bit is the borrow.
  assign sum  = {1'b0, i_data_0} + {1'b0, i_data_1};
  assign diff = {1'b0, i_data_1} - {1'b0, i_data_0};

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle ops evaluated on the live inputs; only used at accept.
  always_comb begin
    res_d = '0;
    ill_d = 1'b0;
    ovf_d = 1'b0;
    cy_d  = 1'b0;
    case (op)
      3'b000: res_d = i_data_0 | i_data_1;
      3'b001: res_d = ~(i_data_0 & i_data_1);
      3'b010: res_d = ~(i_data_0 | i_data_1);
      3'b011: res_d = i_data_0 & i_data_1;
      3'b100: begin
        res_d = sum[WIDTH-1:0];
        cy_d  = sum[WIDTH];
        ovf_d = (i_data_0[WIDTH-1] == i_data_1[WIDTH-1]) &&
                (sum[WIDTH-1] != i_data_0[WIDTH-1]);
      end
      3'b101: begin
        res_d = diff[WIDTH-1:0];
        cy_d  = diff[WIDTH];
        ovf_d = (i_data_1[WIDTH-1] != i_data_0[WIDTH-1]) &&
                (diff[WIDTH-1] != i_data_1[WIDTH-1]);
      end
      3'b111:  ill_d = 1'b1;
      default: res_d = '0;  // 110 is handled by the BUSY path
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            ready_q <= 1'b0;
            if (op == 3'b110) begin
              mcand_q  <= {{WIDTH{1'b0}}, i_data_0};
              mplier_q <= i_data_1;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= BUSY;
            end else begin
              result_q <= res_d;
              flags_q  <= {ill_d, ovf_d, cy_d, (res_d == '0)};
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Last iteration writes the result straight from the adder so
          // DONE is entered after exactly WIDTH BUSY cycles.
          if (cnt_q == LAST) begin
            result_q <= acc_d[WIDTH-1:0];
            flags_q  <= {1'b0, 1'b0, |acc_d[2*WIDTH-1:WIDTH],
                         (acc_d[WIDTH-1:0] == '0)};
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_tt_rebot449_lingret_alu_seq.sv
module tb_tt_rebot449_lingret_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   i_instruction;
  logic [W-1:0] i_data_0, i_data_1;
  logic         i_valid, i_ready;
  logic         o_ready, o_valid;
  logic [W-1:0] o_result;
  logic [3:0]   o_flags;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tt_rebot449_lingret_alu_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_instruction (i_instruction),
    .i_data_0      (i_data_0),
    .i_data_1      (i_data_1),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_result      (o_result),
    .o_flags       (o_flags),
    .o_valid       (o_valid),
    .i_ready       (i_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge, scramble inputs after accept, wait for
  // o_valid and check latency/result/flags. i_ready is held high so the
  // transfer completes after one o_valid cycle.
  task automatic do_op(input string tag, input logic [7:0] instr,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res, input logic [3:0] exp_flg,
                       input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, ".rdy"}, o_ready, 1);
    i_instruction = instr; i_data_0 = a; i_data_1 = b;
    i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_instruction = ~instr; i_data_0 = ~a; i_data_1 = b ^ 8'h5A;
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, o_result, exp_res);
    chk({tag, ".flg"}, o_flags, exp_flg);
    @(negedge clk);
    chk({tag, ".vld_off"}, o_valid, 0);
    chk({tag, ".rdy_back"}, o_ready, 1);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_instruction = '0; i_data_0 = '0; i_data_1 = '0;
    repeat (2) @(negedge clk);
    chk("rst.vld", o_valid, 0);
    chk("rst.res", o_result, 0);
    chk("rst.flg", o_flags, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.rdy", o_ready, 1);

    // Logic ops, A=C5 B=5C
    do_op("or",   8'h00, 8'hC5, 8'h5C, 8'hDD, 4'h0, 1);
    do_op("nand", 8'h01, 8'hC5, 8'h5C, 8'hBB, 4'h0, 1);
    do_op("nor",  8'h02, 8'hC5, 8'h5C, 8'h22, 4'h0, 1);
    do_op("and",  8'h03, 8'hC5, 8'h5C, 8'h44, 4'h0, 1);
    do_op("and0", 8'h03, 8'hF0, 8'h0F, 8'h00, 4'h1, 1);
    // Arithmetic
    do_op("add_cy",  8'h04, 8'hFF, 8'h01, 8'h00, 4'h3, 1);
    do_op("sub_brw", 8'h05, 8'h05, 8'h03, 8'hFE, 4'h2, 1);
    do_op("sub_ovf", 8'h05, 8'h01, 8'h80, 8'h7F, 4'h4, 1);
    do_op("add_hi",  8'h0C, 8'h7F, 8'h01, 8'h80, 4'h4, 1);
    do_op("ill",     8'hFF, 8'h12, 8'h34, 8'h00, 4'h9, 1);
    // Multiply
    do_op("mul_a", 8'h06, 8'h0F, 8'h11, 8'hFF, 4'h0, 9);
    do_op("mul_b", 8'h06, 8'h10, 8'h10, 8'h00, 4'h3, 9);
    do_op("mul_c", 8'h06, 8'hFF, 8'hFF, 8'h01, 4'h2, 9);

    // Backpressure: ADD 0x10+0x20 held for 5 cycles while inputs wiggle
    begin
      int lat;
      @(negedge clk);
      i_ready = 1'b0; i_valid = 1'b1;
      i_instruction = 8'h04; i_data_0 = 8'h10; i_data_1 = 8'h20;
      @(negedge clk);
      lat = 1;
      while (!o_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk("bp.lat", lat, 1);
      for (int i = 0; i < 5; i++) begin
        i_valid = i[0]; i_data_0 = 8'(i * 37); i_data_1 = 8'(i * 11 + 3);
        i_instruction = 8'(i);
        @(negedge clk);
        chk("bp.vld", o_valid, 1);
        chk("bp.rdy", o_ready, 0);
        chk("bp.res", o_result, 8'h30);
        chk("bp.flg", o_flags, 4'h0);
      end
      i_ready = 1'b1; i_valid = 1'b0;
      @(negedge clk);
      chk("bp.xfer", o_valid, 0);
      chk("bp.idle", o_ready, 1);
      @(negedge clk);
      chk("bp.once", o_valid, 0);
    end

    // Reset on 4th BUSY cycle of a MUL (result register currently 0x30)
    @(negedge clk);
    i_instruction = 8'h06; i_data_0 = 8'h0F; i_data_1 = 8'h11;
    i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk);             // BUSY cycle 1
    i_valid = 1'b0;
    repeat (3) @(negedge clk);  // now in BUSY cycle 4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rb.vld", o_valid, 0);
    chk("rb.res", o_result, 0);
    chk("rb.flg", o_flags, 0);
    chk("rb.rdy", o_ready, 1);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (o_valid) seen++;
      end
      chk("rb.no_vld", seen, 0);
    end
    do_op("rb_add", 8'h04, 8'h02, 8'h03, 8'h05, 4'h0, 1);

    // Reset coinciding with an accept: no result comes out
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b1;
    i_instruction = 8'h04; i_data_0 = 8'h01; i_data_1 = 8'h01;
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    chk("ra.vld", o_valid, 0);
    chk("ra.rdy", o_ready, 1);
    @(negedge clk);
    chk("ra.vld2", o_valid, 0);
    chk("ra.res", o_result, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
